// File: rtl/serdes_pkg.sv
// Shared serdes definitions: FSM state encodings and default widths for the PISO/SIPO pair.
package serdes_pkg;

   localparam int unsigned DefDataW = 8;
   localparam int unsigned DefDepth = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b01,
      S_SHIFT = 2'b10
   } state_e;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO: rd_data_o presents the head word whenever not empty.
module fifo_sync #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     rd_en_i,
   output logic [DATA_W-1:0]        rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_wr, do_rd;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // A write while full is refused even if a pop frees a slot in the same cycle.
   assign do_wr = wr_en_i & ~full_o;
   assign do_rd = rd_en_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out: words are queued in a FIFO, then shifted out one bit per serial handshake.
module piso_serializer
   import serdes_pkg::*;
#(
   parameter int unsigned DATA_W    = DefDataW,
   parameter int unsigned DEPTH     = DefDepth,
   parameter int unsigned LSB_FIRST = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [DATA_W-1:0]        data_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   output logic                     data_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic                     first_o,
   output logic                     last_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned CntW = $clog2(DATA_W);
   localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic              pop;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_rd_data;
   logic              in_shift;

   fifo_sync #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (valid_i),
      .wr_data_i (data_i),
      .rd_en_i   (pop),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (level_o)
   );

   // Registered count only, so ready_i never reaches ready_o combinationally.
   assign ready_o = ~fifo_full;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      pop       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_d   = fifo_rd_data;
               bit_cnt_d = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (ready_i) begin
               if (bit_cnt_q == LastCnt) begin
                  bit_cnt_d = '0;
                  // Reload straight from the head so consecutive words run without a gap.
                  if (!fifo_empty) begin
                     pop     = 1'b1;
                     shift_d = fifo_rd_data;
                  end else begin
                     shift_d = '0;
                     state_d = S_IDLE;
                  end
               end else begin
                  shift_d   = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
                  bit_cnt_d = bit_cnt_q + CntW'(1);
               end
            end
         end
         default: begin
            state_d   = S_IDLE;
            shift_d   = '0;
            bit_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign in_shift = (state_q == S_SHIFT);
   assign valid_o  = in_shift;
   assign data_o   = in_shift & ((LSB_FIRST != 0) ? shift_q[0] : shift_q[DATA_W-1]);
   assign first_o  = in_shift & (bit_cnt_q == '0);
   assign last_o   = in_shift & (bit_cnt_q == LastCnt);

endmodule
